im_boot_loader: RTL and testbench

- Serial boot loader that fills the instruction memory before the core starts fetching.
- Takes a byte stream from the UART receiver and parses a framed program image (sync, length, data, checksum).
- Writes little-endian 32-bit words through the instruction memory's write port at byte addresses 0, 4, 8, …, matching the byte-addressed pc indexing.
- Holds the CPU off (cpu_hold) until a frame loads without error.

---
 rtl/im_boot_loader.sv | 174 +++++++++++++++++
 tb/tb_im_boot_loader.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/im_boot_loader.sv
// Serial boot loader: parses a framed byte stream (sync, 16-bit word count, data, XOR checksum)
// and writes little-endian 32-bit words into instruction memory, holding the CPU until success.
module im_boot_loader #(
  parameter int          ADDR_W         = 16,
  parameter int          MAX_WORDS      = 64,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int          TIMEOUT_CYCLES = 100000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic              reload,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err
);

  localparam int CNT_W = $clog2(MAX_WORDS + 1);
  localparam int IDX_W = $clog2(MAX_WORDS);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_LO = 3'd1,
    LEN_HI = 3'd2,
    DATA   = 3'd3,
    CSUM   = 3'd4,
    DONE   = 3'd5,
    ERR    = 3'd6
  } state_t;

  state_t            state_reg, state_next;
  logic [15:0]       len_reg;
  logic [CNT_W-1:0]  word_cnt_reg;
  logic [1:0]        byte_cnt_reg;
  logic [7:0]        csum_reg;
  logic [31:0]       word_buf_reg;
  logic [TO_W-1:0]   idle_cnt_reg;

  logic              byte_ok;
  logic              sync_hit;
  logic              start;
  logic              timeout_hit;
  logic              last_word;
  logic [15:0]       len_full;
  logic [ADDR_W-1:0] wr_addr;

  function automatic logic in_frame(input state_t s);
    return (s == LEN_LO) || (s == LEN_HI) || (s == DATA) || (s == CSUM);
  endfunction

  // A byte coinciding with reload is dropped.
  assign byte_ok     = rx_valid && !reload;
  assign sync_hit    = byte_ok && (rx_data == SYNC_BYTE);
  assign start       = sync_hit && ((state_reg == IDLE) || (state_reg == ERR));
  assign len_full    = {rx_data, len_reg[7:0]};
  assign last_word   = (word_cnt_reg + CNT_W'(1)) == len_reg[CNT_W-1:0];
  // Fires on the cycle whose edge would bring idle_cnt to TIMEOUT_CYCLES.
  assign timeout_hit = in_frame(state_reg) && !byte_ok &&
                       (idle_cnt_reg == TO_W'(TIMEOUT_CYCLES - 1));
  // Index truncated to the image size so the address wraps at MAX_WORDS*4.
  assign wr_addr     = ADDR_W'({word_cnt_reg[IDX_W-1:0], 2'b00});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (reload) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE:   if (sync_hit) state_next = LEN_LO;
        LEN_LO: begin
          if (byte_ok)          state_next = LEN_HI;
          else if (timeout_hit) state_next = ERR;
        end
        LEN_HI: begin
          if (byte_ok) begin
            if (len_full > 16'(MAX_WORDS)) state_next = ERR;
            else if (len_full == 16'd0)    state_next = CSUM;
            else                           state_next = DATA;
          end else if (timeout_hit) begin
            state_next = ERR;
          end
        end
        DATA: begin
          if (byte_ok) begin
            if ((byte_cnt_reg == 2'd3) && last_word) state_next = CSUM;
          end else if (timeout_hit) begin
            state_next = ERR;
          end
        end
        CSUM: begin
          if (byte_ok)          state_next = (rx_data == csum_reg) ? DONE : ERR;
          else if (timeout_hit) state_next = ERR;
        end
        DONE:   state_next = DONE;
        ERR:    if (sync_hit) state_next = LEN_LO;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    cpu_hold  = 1'b1;
    load_done = 1'b0;
    load_err  = 1'b0;
    if (state_reg == DONE) begin
      cpu_hold  = 1'b0;
      load_done = 1'b1;
    end
    if (state_reg == ERR) begin
      load_err = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      im_we        <= 1'b0;
      im_addr      <= '0;
      im_wdata     <= '0;
      len_reg      <= '0;
      word_cnt_reg <= '0;
      byte_cnt_reg <= '0;
      csum_reg     <= '0;
      word_buf_reg <= '0;
      idle_cnt_reg <= '0;
    end else begin
      im_we <= 1'b0;

      if (!in_frame(state_next) || byte_ok) begin
        idle_cnt_reg <= '0;
      end else begin
        idle_cnt_reg <= idle_cnt_reg + TO_W'(1);
      end

      if (reload || start) begin
        len_reg      <= '0;
        word_cnt_reg <= '0;
        byte_cnt_reg <= '0;
        csum_reg     <= '0;
        word_buf_reg <= '0;
      end else if (byte_ok) begin
        case (state_reg)
          LEN_LO: len_reg[7:0]  <= rx_data;
          LEN_HI: len_reg[15:8] <= rx_data;
          DATA: begin
            csum_reg     <= csum_reg ^ rx_data;
            byte_cnt_reg <= byte_cnt_reg + 2'd1;
            word_buf_reg[{byte_cnt_reg, 3'b000} +: 8] <= rx_data;
            if (byte_cnt_reg == 2'd3) begin
              im_we        <= 1'b1;
              im_addr      <= wr_addr;
              im_wdata     <= {rx_data, word_buf_reg[23:0]};
              word_cnt_reg <= word_cnt_reg + CNT_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_im_boot_loader.sv
// Directed bench for im_boot_loader: good/empty/oversize/bad-checksum frames, timeout,
// reload and asynchronous reset, with hand-computed expected writes and status.
module tb_im_boot_loader;

  localparam int TO = 50;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        reload;
  logic        im_we;
  logic [15:0] im_addr;
  logic [31:0] im_wdata;
  logic        cpu_hold;
  logic        load_done;
  logic        load_err;

  int errors = 0;
  int checks = 0;
  int wr_count = 0;
  int wr_base;

  im_boot_loader #(
    .ADDR_W(16), .MAX_WORDS(64), .SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data), .reload(reload),
    .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
    .cpu_hold(cpu_hold), .load_done(load_done), .load_err(load_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (im_we === 1'b1) begin
      wr_count++;
      $display("write addr=%04h data=%08h", im_addr, im_wdata);
    end
  end

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    $display("rx byte %02h -> hold=%0b done=%0b err=%0b", b, cpu_hold, load_done, load_err);
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    @(posedge clk);
    #1;
    reload = 1'b0;
    $display("reload -> hold=%0b done=%0b err=%0b", cpu_hold, load_done, load_err);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; reload = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({im_we, im_addr, im_wdata, cpu_hold, load_done, load_err} !== {1'b0, 16'h0, 32'h0, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_outputs: got we=%0b addr=%h data=%h hold=%0b done=%0b err=%0b, want 0/0000/00000000/1/0/0",
               im_we, im_addr, im_wdata, cpu_hold, load_done, load_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_good_frame();
    wr_base = wr_count;
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h13); send_byte(8'h04); send_byte(8'hA0); send_byte(8'h00);
    checks++;
    if ({im_we, im_addr, im_wdata} !== {1'b1, 16'h0000, 32'h00A00413}) begin
      errors++;
      $display("FAIL good_word0: got we=%0b addr=%h data=%h, want 1/0000/00a00413", im_we, im_addr, im_wdata);
    end
    send_byte(8'h93);
    checks++;
    if (im_we !== 1'b0) begin
      errors++;
      $display("FAIL good_we_single_pulse: got we=%0b, want 0", im_we);
    end
    send_byte(8'h04); send_byte(8'hC0); send_byte(8'h00);
    checks++;
    if ({im_we, im_addr, im_wdata} !== {1'b1, 16'h0004, 32'h00C00493}) begin
      errors++;
      $display("FAIL good_word1: got we=%0b addr=%h data=%h, want 1/0004/00c00493", im_we, im_addr, im_wdata);
    end
    send_byte(8'hE0);
    checks++;
    if ({load_done, cpu_hold, load_err} !== 3'b100) begin
      errors++;
      $display("FAIL good_status: got done=%0b hold=%0b err=%0b, want 1/0/0", load_done, cpu_hold, load_err);
    end
    checks++;
    if (wr_count - wr_base !== 2) begin
      errors++;
      $display("FAIL good_write_count: got %0d, want 2", wr_count - wr_base);
    end
  endtask

  task automatic test_reload_done();
    pulse_reload();
    checks++;
    if ({cpu_hold, load_done, load_err} !== 3'b100) begin
      errors++;
      $display("FAIL reload_status: got hold=%0b done=%0b err=%0b, want 1/0/0", cpu_hold, load_done, load_err);
    end
    // In IDLE, non-sync bytes that would form an empty frame are ignored.
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    checks++;
    if ({cpu_hold, load_done, load_err} !== 3'b100) begin
      errors++;
      $display("FAIL reload_idle_ignores: got hold=%0b done=%0b err=%0b, want 1/0/0", cpu_hold, load_done, load_err);
    end
  endtask

  task automatic test_empty();
    wr_base = wr_count;
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    checks++;
    if ({load_done, cpu_hold, load_err} !== 3'b100 || wr_count != wr_base) begin
      errors++;
      $display("FAIL empty_ok: got done=%0b hold=%0b err=%0b writes=%0d, want 1/0/0 writes=0",
               load_done, cpu_hold, load_err, wr_count - wr_base);
    end
    pulse_reload();
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00); send_byte(8'h01);
    checks++;
    if ({load_err, cpu_hold, load_done} !== 3'b110) begin
      errors++;
      $display("FAIL empty_bad_csum: got err=%0b hold=%0b done=%0b, want 1/1/0", load_err, cpu_hold, load_done);
    end
  endtask

  task automatic test_oversize();
    pulse_reload();
    wr_base = wr_count;
    send_byte(8'h55); send_byte(8'hFF);
    checks++;
    if (load_err !== 1'b0) begin
      errors++;
      $display("FAIL oversize_presync_ignored: got err=%0b, want 0", load_err);
    end
    send_byte(8'hA5); send_byte(8'h41);
    checks++;
    if (load_err !== 1'b0) begin
      errors++;
      $display("FAIL oversize_len_lo: got err=%0b, want 0", load_err);
    end
    send_byte(8'h00);
    checks++;
    if ({load_err, cpu_hold, load_done} !== 3'b110 || wr_count != wr_base) begin
      errors++;
      $display("FAIL oversize_err: got err=%0b hold=%0b done=%0b writes=%0d, want 1/1/0 writes=0",
               load_err, cpu_hold, load_done, wr_count - wr_base);
    end
  endtask

  task automatic test_bad_csum_then_retry();
    logic [7:0] frame [12];
    frame = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h04, 8'hA0, 8'h00, 8'h93, 8'h04, 8'hC0, 8'h00, 8'hE1};
    wr_base = wr_count;
    for (int i = 0; i < 12; i++) send_byte(frame[i]);
    checks++;
    if ({load_err, load_done, cpu_hold} !== 3'b101 || wr_count - wr_base != 2) begin
      errors++;
      $display("FAIL bad_csum: got err=%0b done=%0b hold=%0b writes=%0d, want 1/0/1 writes=2",
               load_err, load_done, cpu_hold, wr_count - wr_base);
    end
    frame[11] = 8'hE0;
    wr_base = wr_count;
    for (int i = 0; i < 12; i++) send_byte(frame[i]);
    checks++;
    if ({load_done, load_err, cpu_hold} !== 3'b100 || wr_count - wr_base != 2) begin
      errors++;
      $display("FAIL retry_good: got done=%0b err=%0b hold=%0b writes=%0d, want 1/0/0 writes=2",
               load_done, load_err, cpu_hold, wr_count - wr_base);
    end
  endtask

  task automatic test_timeout();
    pulse_reload();
    wr_base = wr_count;
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00); send_byte(8'h13); send_byte(8'h04);
    repeat (TO - 1) @(posedge clk);
    #1;
    checks++;
    if (load_err !== 1'b0) begin
      errors++;
      $display("FAIL timeout_early: got err=%0b after %0d idle cycles, want 0", load_err, TO - 1);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({load_err, cpu_hold} !== 2'b11 || wr_count != wr_base) begin
      errors++;
      $display("FAIL timeout_err: got err=%0b hold=%0b writes=%0d after %0d idle cycles, want 1/1 writes=0",
               load_err, cpu_hold, wr_count - wr_base, TO);
    end
  endtask

  task automatic test_reset_mid_data();
    wr_base = wr_count;
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h13); send_byte(8'h04); send_byte(8'hA0);
    @(negedge clk);
    rx_data  = 8'h00;
    rx_valid = 1'b1;
    rst_n    = 1'b0;
    #1;
    checks++;
    if ({im_we, im_addr, im_wdata, cpu_hold, load_done, load_err} !== {1'b0, 16'h0, 32'h0, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL async_reset_outputs: got we=%0b addr=%h data=%h hold=%0b done=%0b err=%0b, want 0/0000/00000000/1/0/0",
               im_we, im_addr, im_wdata, cpu_hold, load_done, load_err);
    end
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (wr_count != wr_base) begin
      errors++;
      $display("FAIL reset_no_write: got writes=%0d, want 0", wr_count - wr_base);
    end
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    checks++;
    if ({load_done, cpu_hold, load_err} !== 3'b100) begin
      errors++;
      $display("FAIL after_reset_load: got done=%0b hold=%0b err=%0b, want 1/0/0", load_done, cpu_hold, load_err);
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_reload_done();
    test_empty();
    test_oversize();
    test_bad_csum_then_retry();
    test_timeout();
    test_reset_mid_data();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
